instruction_fetch_unit: RTL

Fetch-side initiator for the byte-addressed, big-endian instruction memory. The memory registers its read data: an address driven during cycle N appears on its output in cycle N+1.
- Holds the PC and drives the memory address.
- Captures returned words into a small prefetch queue.
- Presents instruction and PC to decode over a valid/ready handshake.
- Handles branch/jump redirects by squashing in-flight and queued fetches.

---
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instruction_fetch_unit                                         |
// | Summary : PC sequencer, prefetch queue and redirect flush for decode.     |
// |           FETCH_PERF_EN adds stall/flush performance counters.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] instructionAdress,
  input  logic [31:0] instructionIn,
  output logic        instrValid,
  output logic [31:0] instrOut,
  output logic [31:0] instrPc,
  input  logic        decodeReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetchStallCycles,
  output logic [31:0] fetchFlushCount
`endif
);

  localparam int unsigned      c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH     = (c_CNT_W + 1)'(DEPTH);
  localparam logic [31:0]      c_MEM_BYTES = 32'(MEM_BYTES);

  logic [31:0]        r_pc;
  logic [31:0]        r_pc_in_flight;
  logic               r_pending;
  logic [31:0]        r_q_data [DEPTH];
  logic [31:0]        r_q_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [c_CNT_W:0]   w_occ;
  logic [31:0]        w_pc_next;
  logic [31:0]        w_target;

  assign instructionAdress = r_pc;
  assign instrValid        = (r_count != '0);
  assign instrOut          = r_q_data[r_head];
  assign instrPc           = r_q_pc[r_head];

  // Credit counts the in-flight word as occupied so a full queue never overflows.
  assign w_pop     = instrValid && decodeReady;
  assign w_push    = r_pending && !redirectValid;
  assign w_occ     = (c_CNT_W + 1)'(r_count) + (c_CNT_W + 1)'(r_pending)
                   - (c_CNT_W + 1)'(w_pop);
  assign w_issue   = !redirectValid && (w_occ < c_DEPTH);
  assign w_pc_next = ((r_pc + 32'd4) >= c_MEM_BYTES) ? 32'd0 : (r_pc + 32'd4);
  assign w_target  = (redirectTarget & ~32'd3) % c_MEM_BYTES;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_pc_in_flight <= '0;
      r_pending      <= 1'b0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (redirectValid) begin
      // A same-edge pop is already consumed by decode; everything else is squashed.
      r_pc      <= w_target;
      r_pending <= 1'b0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      if (w_issue) begin
        r_pending      <= 1'b1;
        r_pc_in_flight <= r_pc;
        r_pc           <= w_pc_next;
      end else begin
        r_pending <= 1'b0;
      end
      if (w_push) begin
        r_q_data[r_tail] <= instructionIn;
        r_q_pc[r_tail]   <= r_pc_in_flight;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!instrValid && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (redirectValid && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign fetchStallCycles = r_stall_cycles;
  assign fetchFlushCount  = r_flush_count;
`endif

endmodule
`default_nettype wire
